frame_buffer_manager: RTL and testbench

Triple-buffer frame scheduler in the clk_100Mhz domain, between the capture-side AXI4 burst writer and the HDMI-side AXI4 burst reader. It assigns each a DDR frame base address. The writer always gets a buffer the reader is not using. The reader always gets the newest fully written frame. Tearing and writer stalls are eliminated.

---
 rtl/frame_buffer_manager.sv | 198 +++++++++++++++++++
 tb/tb_frame_buffer_manager.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/frame_buffer_manager.sv
`default_nettype none
// ============================================================================
// Module      : frame_buffer_manager
// Description : Triple-buffer frame scheduler between a capture-side AXI
//               writer and an HDMI-side AXI reader. The writer always gets a
//               buffer the reader is not using; the reader always gets the
//               newest fully written frame.
//               Optional macro FB_STATS_EN enables the drop/repeat counters.
// Revision    : 1.0 - initial release
// ============================================================================
module frame_buffer_manager #(
  parameter logic [31:0] FRAME_BASE_ADDR = 32'h0100_0000,
  parameter logic [31:0] FRAME_STRIDE    = 32'h0004_0000,
  parameter int          AXI_ADDR_WIDTH  = 32
) (
  input  logic                      clk_100Mhz,
  input  logic                      rst_n,
  input  logic                      wr_frame_start,
  input  logic                      wr_frame_done,
  input  logic                      rd_frame_start,
  input  logic                      rd_frame_done,
  output logic                      wr_grant,
  output logic [1:0]                wr_buf_idx,
  output logic [AXI_ADDR_WIDTH-1:0] wr_base_addr,
  output logic                      rd_grant,
  output logic [1:0]                rd_buf_idx,
  output logic [AXI_ADDR_WIDTH-1:0] rd_base_addr,
  output logic [15:0]               frame_drop_cnt,
  output logic [15:0]               frame_repeat_cnt
);

  localparam int CALC_W = (AXI_ADDR_WIDTH > 32) ? AXI_ADDR_WIDTH : 32;

  typedef enum logic [1:0] {FREE = 2'd0, WRITING = 2'd1, READY = 2'd2, READING = 2'd3} buf_state_e;
  typedef enum logic {W_IDLE = 1'b0, W_ACTIVE = 1'b1} wr_state_e;
  typedef enum logic {R_IDLE = 1'b0, R_ACTIVE = 1'b1} rd_state_e;

  logic [3:0]  in_d1_q;
  logic        wr_start_p, wr_done_p, rd_start_p, rd_done_p;

  buf_state_e  buf_q [3];
  buf_state_e  buf_d [3];
  wr_state_e   wr_state_q, wr_state_d;
  rd_state_e   rd_state_q, rd_state_d;
  logic [1:0]  wr_idx_q, wr_idx_d;
  logic [1:0]  rd_idx_q, rd_idx_d;
  logic [1:0]  latest_idx_q, latest_idx_d;
  logic        latest_valid_q, latest_valid_d;
  logic        latest_read_q, latest_read_d;

  // Rising-edge detection of the four level inputs
  assign wr_start_p = wr_frame_start & ~in_d1_q[0];
  assign wr_done_p  = wr_frame_done  & ~in_d1_q[1];
  assign rd_start_p = rd_frame_start & ~in_d1_q[2];
  assign rd_done_p  = rd_frame_done  & ~in_d1_q[3];

  function automatic logic [AXI_ADDR_WIDTH-1:0] addr_of(input logic [1:0] idx);
    logic [CALC_W-1:0] sum;
    sum = CALC_W'(FRAME_BASE_ADDR) + CALC_W'(idx) * CALC_W'(FRAME_STRIDE);
    return sum[AXI_ADDR_WIDTH-1:0];
  endfunction

`ifdef FB_STATS_EN
  logic        drop_evt, repeat_evt;
  logic [15:0] drop_cnt_q, drop_cnt_d;
  logic [15:0] repeat_cnt_q, repeat_cnt_d;
`endif

  // Scheduler: releases, then publish, then reader acquire, then writer allocate
  always_comb begin
    buf_d          = buf_q;
    wr_state_d     = wr_state_q;
    rd_state_d     = rd_state_q;
    wr_idx_d       = wr_idx_q;
    rd_idx_d       = rd_idx_q;
    latest_idx_d   = latest_idx_q;
    latest_valid_d = latest_valid_q;
    latest_read_d  = latest_read_q;
`ifdef FB_STATS_EN
    drop_evt       = 1'b0;
    repeat_evt     = 1'b0;
`endif

    // Reader release; a still-latest buffer stays available for re-reading
    if (rd_state_q == R_ACTIVE && (rd_start_p || rd_done_p)) begin
      buf_d[rd_idx_q] = (rd_idx_q == latest_idx_q) ? READY : FREE;
      rd_state_d      = R_IDLE;
    end

    // Writer abort: a new start while active discards the partial frame
    if (wr_state_q == W_ACTIVE && wr_start_p) begin
      buf_d[wr_idx_q] = FREE;
      wr_state_d      = W_IDLE;
    end

    // Writer publish; abort takes precedence over a simultaneous done
    if (wr_state_q == W_ACTIVE && wr_done_p && !wr_start_p) begin
      if (latest_valid_q && buf_d[latest_idx_q] == READY) begin
        buf_d[latest_idx_q] = FREE;
`ifdef FB_STATS_EN
        drop_evt = ~latest_read_q;
`endif
      end
      buf_d[wr_idx_q] = READY;
      latest_idx_d    = wr_idx_q;
      latest_valid_d  = 1'b1;
      latest_read_d   = 1'b0;
      wr_state_d      = W_IDLE;
    end

    // Reader acquire sees any frame published in this same cycle
    if (rd_start_p && rd_state_d == R_IDLE && latest_valid_d) begin
`ifdef FB_STATS_EN
      repeat_evt = latest_read_d;
`endif
      buf_d[latest_idx_d] = READING;
      rd_idx_d            = latest_idx_d;
      latest_read_d       = 1'b1;
      rd_state_d          = R_ACTIVE;
    end

    // Writer allocate: lowest FREE buffer, including ones freed this cycle
    if (wr_start_p && wr_state_d == W_IDLE) begin
      if (buf_d[0] == FREE) begin
        buf_d[0] = WRITING; wr_idx_d = 2'd0; wr_state_d = W_ACTIVE;
      end else if (buf_d[1] == FREE) begin
        buf_d[1] = WRITING; wr_idx_d = 2'd1; wr_state_d = W_ACTIVE;
      end else if (buf_d[2] == FREE) begin
        buf_d[2] = WRITING; wr_idx_d = 2'd2; wr_state_d = W_ACTIVE;
      end
    end
  end

  // State registers; reset drops all ownership immediately
  always_ff @(posedge clk_100Mhz or negedge rst_n) begin
    if (!rst_n) begin
      in_d1_q        <= 4'b0000;
      buf_q[0]       <= FREE;
      buf_q[1]       <= FREE;
      buf_q[2]       <= FREE;
      wr_state_q     <= W_IDLE;
      rd_state_q     <= R_IDLE;
      wr_idx_q       <= 2'd0;
      rd_idx_q       <= 2'd0;
      latest_idx_q   <= 2'd0;
      latest_valid_q <= 1'b0;
      latest_read_q  <= 1'b0;
    end else begin
      in_d1_q        <= {rd_frame_done, rd_frame_start, wr_frame_done, wr_frame_start};
      buf_q          <= buf_d;
      wr_state_q     <= wr_state_d;
      rd_state_q     <= rd_state_d;
      wr_idx_q       <= wr_idx_d;
      rd_idx_q       <= rd_idx_d;
      latest_idx_q   <= latest_idx_d;
      latest_valid_q <= latest_valid_d;
      latest_read_q  <= latest_read_d;
    end
  end

`ifdef FB_STATS_EN
  // Saturating statistics counters
  always_comb begin
    drop_cnt_d   = drop_cnt_q;
    repeat_cnt_d = repeat_cnt_q;
    if (drop_evt && drop_cnt_q != 16'hFFFF)
      drop_cnt_d = drop_cnt_q + 16'd1;
    if (repeat_evt && repeat_cnt_q != 16'hFFFF)
      repeat_cnt_d = repeat_cnt_q + 16'd1;
  end

  // Counter registers
  always_ff @(posedge clk_100Mhz or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt_q   <= 16'h0000;
      repeat_cnt_q <= 16'h0000;
    end else begin
      drop_cnt_q   <= drop_cnt_d;
      repeat_cnt_q <= repeat_cnt_d;
    end
  end

  assign frame_drop_cnt   = drop_cnt_q;
  assign frame_repeat_cnt = repeat_cnt_q;
`else
  assign frame_drop_cnt   = 16'h0000;
  assign frame_repeat_cnt = 16'h0000;
`endif

  assign wr_grant     = (wr_state_q == W_ACTIVE);
  assign rd_grant     = (rd_state_q == R_ACTIVE);
  assign wr_buf_idx   = wr_idx_q;
  assign rd_buf_idx   = rd_idx_q;
  assign wr_base_addr = addr_of(wr_idx_q);
  assign rd_base_addr = addr_of(rd_idx_q);

endmodule
`default_nettype wire

// File: tb/tb_frame_buffer_manager.sv
`default_nettype none
// ============================================================================
// Module      : tb_frame_buffer_manager
// Description : Directed table-driven bench for frame_buffer_manager, plus a
//               hand-written asynchronous mid-frame reset sequence.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_frame_buffer_manager;

  localparam logic [31:0] BASE   = 32'h0100_0000;
  localparam logic [31:0] STRIDE = 32'h0004_0000;

  logic        clk_100Mhz;
  logic        rst_n;
  logic        wr_frame_start, wr_frame_done, rd_frame_start, rd_frame_done;
  logic        wr_grant, rd_grant;
  logic [1:0]  wr_buf_idx, rd_buf_idx;
  logic [31:0] wr_base_addr, rd_base_addr;
  logic [15:0] frame_drop_cnt, frame_repeat_cnt;

  int n_vec  = 0;
  int n_fail = 0;

  typedef struct {
    logic       ws, wd, rs, rd;
    logic       wg;
    logic [1:0] wi;
    logic       rg;
    logic [1:0] ri;
    int         drop, rep;
  } vec_t;

  vec_t vecs[$];

  frame_buffer_manager #(
    .FRAME_BASE_ADDR (BASE),
    .FRAME_STRIDE    (STRIDE),
    .AXI_ADDR_WIDTH  (32)
  ) dut (
    .clk_100Mhz       (clk_100Mhz),
    .rst_n            (rst_n),
    .wr_frame_start   (wr_frame_start),
    .wr_frame_done    (wr_frame_done),
    .rd_frame_start   (rd_frame_start),
    .rd_frame_done    (rd_frame_done),
    .wr_grant         (wr_grant),
    .wr_buf_idx       (wr_buf_idx),
    .wr_base_addr     (wr_base_addr),
    .rd_grant         (rd_grant),
    .rd_buf_idx       (rd_buf_idx),
    .rd_base_addr     (rd_base_addr),
    .frame_drop_cnt   (frame_drop_cnt),
    .frame_repeat_cnt (frame_repeat_cnt)
  );

  initial clk_100Mhz = 1'b0;
  always #5 clk_100Mhz = ~clk_100Mhz;

  function automatic int exp_cnt(input int v);
`ifdef FB_STATS_EN
    return v;
`else
    return 0 * v;
`endif
  endfunction

  function automatic logic [31:0] exp_addr(input logic [1:0] idx);
    return BASE + 32'(idx) * STRIDE;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic wg, input logic [1:0] wi,
                           input logic rg, input logic [1:0] ri, input int drop, input int rep);
    check({tag, " wr_grant"},     32'(wr_grant),         32'(wg));
    check({tag, " wr_buf_idx"},   32'(wr_buf_idx),       32'(wi));
    check({tag, " wr_base_addr"}, wr_base_addr,          exp_addr(wi));
    check({tag, " rd_grant"},     32'(rd_grant),         32'(rg));
    check({tag, " rd_buf_idx"},   32'(rd_buf_idx),       32'(ri));
    check({tag, " rd_base_addr"}, rd_base_addr,          exp_addr(ri));
    check({tag, " drop_cnt"},     32'(frame_drop_cnt),   32'(exp_cnt(drop)));
    check({tag, " repeat_cnt"},   32'(frame_repeat_cnt), 32'(exp_cnt(rep)));
  endtask

  task automatic drive(input logic ws, input logic wd, input logic rs, input logic rd);
    wr_frame_start = ws;
    wr_frame_done  = wd;
    rd_frame_start = rs;
    rd_frame_done  = rd;
  endtask

  initial begin
    //            ws    wd    rs    rd    wg    wi    rg    ri   drop rep
    vecs.push_back('{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0, 0, 0}); // 1 rd start, no frame
    vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0, 0, 0}); // 2
    vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 2'd0, 0, 0}); // 3 wr start -> 0
    vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 2'd0, 0, 0}); // 4 held level, no event
    vecs.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0, 0, 0}); // 5 publish 0
    vecs.push_back('{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 1'b1, 2'd0, 0, 0}); // 6 reader takes 0
    vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'd1, 1'b1, 2'd0, 0, 0}); // 7 wr -> 1
    vecs.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd1, 1'b1, 2'd0, 0, 0}); // 8 publish 1
    vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'd2, 1'b1, 2'd0, 0, 0}); // 9 wr -> 2
    vecs.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd2, 1'b1, 2'd0, 1, 0}); // 10 publish 2, drop 1
    vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'd1, 1'b1, 2'd0, 1, 0}); // 11 wr -> 1
    vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'd1, 1'b0, 2'd0, 1, 0}); // 12 rd done
    vecs.push_back('{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 2'd1, 1'b1, 2'd2, 1, 0}); // 13 rd -> 2
    vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'd1, 1'b0, 2'd2, 1, 0}); // 14 rd done
    vecs.push_back('{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 2'd1, 1'b1, 2'd2, 1, 1}); // 15 repeat
    vecs.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd1, 1'b1, 2'd2, 1, 1}); // 16 publish 1
    vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 1'b1, 2'd2, 1, 1}); // 17 wr -> 0
    vecs.push_back('{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 1'b1, 2'd0, 2, 1}); // 18 publish+restart
    vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 2'd0, 2, 1}); // 19
    vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'd1, 1'b1, 2'd0, 2, 1}); // 20 wr -> 1
    vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd1, 1'b1, 2'd0, 2, 1}); // 21
    vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'd1, 1'b1, 2'd0, 2, 1}); // 22 abort, same idx
    vecs.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd1, 1'b1, 2'd0, 2, 1}); // 23 publish 1
    vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'd2, 1'b1, 2'd0, 2, 1}); // 24 wr -> 2
    vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'd2, 1'b0, 2'd0, 2, 1}); // 25 rd done, 0 freed
    vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 2'd0, 2, 1}); // 26 abort -> 0
    vecs.push_back('{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 1'b1, 2'd0, 3, 1}); // 27 publish+acquire
    vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 2'd0, 3, 1}); // 28
    vecs.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 2'd0, 3, 1}); // 29 done in idle ignored
    vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'd1, 1'b1, 2'd0, 3, 1}); // 30 wr -> 1

    drive(1'b0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b0;
    repeat (2) @(posedge clk_100Mhz);
    #1 rst_n = 1'b1;
    n_vec++;
    check_all("reset", 1'b0, 2'd0, 1'b0, 2'd0, 0, 0);

    foreach (vecs[k]) begin
      drive(vecs[k].ws, vecs[k].wd, vecs[k].rs, vecs[k].rd);
      @(posedge clk_100Mhz);
      #1;
      n_vec++;
      check_all($sformatf("vec%0d", k + 1), vecs[k].wg, vecs[k].wi,
                vecs[k].rg, vecs[k].ri, vecs[k].drop, vecs[k].rep);
    end

    // Both grants high: asynchronous reset between clock edges
    #2 rst_n = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    n_vec++;
    check_all("async_reset", 1'b0, 2'd0, 1'b0, 2'd0, 0, 0);
    @(posedge clk_100Mhz);
    #1 rst_n = 1'b1;

    // First reader start after reset is ignored
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    @(posedge clk_100Mhz);
    #1;
    n_vec++;
    check_all("post_reset_rd", 1'b0, 2'd0, 1'b0, 2'd0, 0, 0);

    // Writer restarts at buffer 0
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    @(posedge clk_100Mhz);
    #1;
    n_vec++;
    check_all("post_reset_wr", 1'b1, 2'd0, 1'b0, 2'd0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
